ast_pipe_slice: RTL and testbench

- Parametrised Avalon-ST retiming pipeline, single clock domain.
- Inserted between chip I/O and stream cores such as bloom_filter. Replaces plain flop-through boundary registers.
- Every stage registers data/valid and also backpressure (ready), so no combinational path runs from ast_source_ready_i to ast_sink_ready_o when READY_REG=1.
- Adds occupancy reporting and a sticky SOP/EOP framing-error monitor.

---
 rtl/ast_pipe_slice_if.sv | 18 +
 rtl/ast_pipe_slice.sv | 143 ++++++++++++++
 tb/tb_ast_pipe_slice.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ast_pipe_slice_if.sv
// Avalon-ST beat bundle shared by the sink and source sides of ast_pipe_slice.
// Handshake: a beat transfers on every clock edge where valid && ready are
// both high (ready latency 0). While valid is high the payload
// {data, empty, sop, eop} is the beat on offer; ready may change freely.
interface ast_pipe_slice_if #(
    parameter int DATA_W  = 64,
    parameter int EMPTY_W = 3
);
    logic [DATA_W-1:0]  data;
    logic               valid;
    logic               ready;
    logic [EMPTY_W-1:0] empty;
    logic               sop;
    logic               eop;

    modport master (output data, valid, empty, sop, eop, input ready);
    modport slave  (input data, valid, empty, sop, eop, output ready);
endinterface

// File: rtl/ast_pipe_slice.sv
// Avalon-ST retiming pipeline: STAGES cascaded slices (skid or forward type),
// a held-beat occupancy counter and a sticky SOP/EOP framing monitor.
module ast_pipe_slice #(
    parameter int SYMBOLS   = 8,
    parameter int SYMBOL_W  = 8,
    parameter int EMPTY_W   = 3,
    parameter int STAGES    = 2,
    parameter int READY_REG = 1,
    parameter int FILL_W    = $clog2(2*STAGES+1)
) (
    input  logic              main_clk_i,
    input  logic              main_arst_i,
    ast_pipe_slice_if.slave   sink,
    ast_pipe_slice_if.master  source,
    output logic [FILL_W-1:0] fill_o,
    output logic              proto_err_o,
    input  logic              proto_err_clr_i
);
    localparam int DATA_W = SYMBOLS * SYMBOL_W;
    localparam int PW     = DATA_W + EMPTY_W + 2;

    typedef enum logic {FR_IDLE, FR_IN_PKT} fr_state_t;

    // Inter-stage links: index i feeds stage i, index i+1 is its output.
    logic [STAGES:0]         stg_valid;
    logic [STAGES:0]         stg_ready;
    logic [STAGES:0][PW-1:0] stg_pay;

    logic      alive_q;
    logic      sink_fire;
    logic      src_fire;
    logic      frame_err;
    fr_state_t fr_state;

    // Holds the sink closed from reset until the first edge after release.
    always_ff @(posedge main_clk_i or posedge main_arst_i) begin
        if (main_arst_i) alive_q <= 1'b0;
        else             alive_q <= 1'b1;
    end

    assign stg_valid[0]     = sink.valid && alive_q;
    assign stg_pay[0]       = {sink.data, sink.empty, sink.sop, sink.eop};
    assign sink.ready       = stg_ready[0] && alive_q;

    assign source.valid     = stg_valid[STAGES];
    assign {source.data, source.empty, source.sop, source.eop} = stg_pay[STAGES];
    assign stg_ready[STAGES] = source.ready;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        if (READY_REG != 0) begin : g_skid
            logic          m_valid, s_valid, rdy_q;
            logic [PW-1:0] m_pay, s_pay;
            logic          in_fire, out_fire, m_free;
            logic          load_m_in, load_m_s, load_s;
            logic          m_valid_nxt, s_valid_nxt;

            assign in_fire     = stg_valid[i] && rdy_q;
            assign out_fire    = m_valid && stg_ready[i+1];
            assign m_free      = !m_valid || out_fire;
            assign load_m_s    = s_valid && out_fire;
            assign load_m_in   = in_fire && m_free;
            assign load_s      = in_fire && !m_free;
            assign m_valid_nxt = load_m_s || load_m_in || (m_valid && !out_fire);
            assign s_valid_nxt = load_s || (s_valid && !out_fire);

            // Valid flags and the registered ready (open while skid is empty).
            always_ff @(posedge main_clk_i or posedge main_arst_i) begin
                if (main_arst_i) begin
                    m_valid <= 1'b0;
                    s_valid <= 1'b0;
                    rdy_q   <= 1'b0;
                end else begin
                    m_valid <= m_valid_nxt;
                    s_valid <= s_valid_nxt;
                    rdy_q   <= !s_valid_nxt;
                end
            end

            // Payload registers: skid refills main first, so order is kept.
            always_ff @(posedge main_clk_i) begin
                if (load_m_s)       m_pay <= s_pay;
                else if (load_m_in) m_pay <= stg_pay[i];
                if (load_s)         s_pay <= stg_pay[i];
            end

            assign stg_ready[i]   = rdy_q;
            assign stg_valid[i+1] = m_valid;
            assign stg_pay[i+1]   = m_pay;
        end else begin : g_fwd
            logic          m_valid;
            logic [PW-1:0] m_pay;
            logic          in_fire, out_fire;

            // Ready is open if any stage from here down is empty or the
            // source accepts; built from flops directly to avoid a chain.
            assign stg_ready[i] = source.ready || ((~stg_valid[STAGES:i+1]) != '0);
            assign in_fire      = stg_valid[i] && stg_ready[i];
            assign out_fire     = m_valid && stg_ready[i+1];

            // Single holding register valid flag.
            always_ff @(posedge main_clk_i or posedge main_arst_i) begin
                if (main_arst_i)   m_valid <= 1'b0;
                else if (in_fire)  m_valid <= 1'b1;
                else if (out_fire) m_valid <= 1'b0;
            end

            // Payload capture on accept.
            always_ff @(posedge main_clk_i) begin
                if (in_fire) m_pay <= stg_pay[i];
            end

            assign stg_valid[i+1] = m_valid;
            assign stg_pay[i+1]   = m_pay;
        end
    end

    assign sink_fire = sink.valid && sink.ready;
    assign src_fire  = source.valid && source.ready;
    assign frame_err = sink_fire &&
                       ((fr_state == FR_IDLE) ? !sink.sop : sink.sop);

    // Occupancy: beats in minus beats out, across every stage.
    always_ff @(posedge main_clk_i or posedge main_arst_i) begin
        if (main_arst_i)                  fill_o <= '0;
        else if (sink_fire && !src_fire)  fill_o <= fill_o + FILL_W'(1);
        else if (!sink_fire && src_fire)  fill_o <= fill_o - FILL_W'(1);
    end

    // Framing monitor FSM with sticky error; a new error beats a clear.
    always_ff @(posedge main_clk_i or posedge main_arst_i) begin
        if (main_arst_i) begin
            fr_state    <= FR_IDLE;
            proto_err_o <= 1'b0;
        end else begin
            if (frame_err)            proto_err_o <= 1'b1;
            else if (proto_err_clr_i) proto_err_o <= 1'b0;
            if (sink_fire) begin
                if (sink.sop)      fr_state <= sink.eop ? FR_IDLE : FR_IN_PKT;
                else if (sink.eop) fr_state <= FR_IDLE;
            end
        end
    end
endmodule

// File: tb/tb_ast_pipe_slice.sv
// Bench for ast_pipe_slice: directed sequences on a STAGES=2 skid pipe plus a
// random-ready scoreboard run on STAGES=3 skid and forward pipes.
module tb_ast_pipe_slice;
  localparam int DW = 64;
  localparam int EW = 3;
  localparam int PW = DW + EW + 2;
  localparam int FWA = $clog2(5);
  localparam int FWR = $clog2(7);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;

  ast_pipe_slice_if #(.DATA_W(DW), .EMPTY_W(EW)) a_in ();
  ast_pipe_slice_if #(.DATA_W(DW), .EMPTY_W(EW)) a_out ();
  ast_pipe_slice_if #(.DATA_W(DW), .EMPTY_W(EW)) b_in ();
  ast_pipe_slice_if #(.DATA_W(DW), .EMPTY_W(EW)) b_out ();
  ast_pipe_slice_if #(.DATA_W(DW), .EMPTY_W(EW)) c_in ();
  ast_pipe_slice_if #(.DATA_W(DW), .EMPTY_W(EW)) c_out ();

  logic [FWA-1:0] a_fill;
  logic           a_err, a_clr;
  logic [FWR-1:0] b_fill, c_fill;
  logic           b_err, c_err;

  ast_pipe_slice #(.SYMBOLS(8), .SYMBOL_W(8), .EMPTY_W(EW), .STAGES(2), .READY_REG(1)) dut_a (
    .main_clk_i(clk), .main_arst_i(rst), .sink(a_in), .source(a_out),
    .fill_o(a_fill), .proto_err_o(a_err), .proto_err_clr_i(a_clr));
  ast_pipe_slice #(.SYMBOLS(8), .SYMBOL_W(8), .EMPTY_W(EW), .STAGES(3), .READY_REG(1)) dut_b (
    .main_clk_i(clk), .main_arst_i(rst), .sink(b_in), .source(b_out),
    .fill_o(b_fill), .proto_err_o(b_err), .proto_err_clr_i(1'b0));
  ast_pipe_slice #(.SYMBOLS(8), .SYMBOL_W(8), .EMPTY_W(EW), .STAGES(3), .READY_REG(0)) dut_c (
    .main_clk_i(clk), .main_arst_i(rst), .sink(c_in), .source(c_out),
    .fill_o(c_fill), .proto_err_o(c_err), .proto_err_clr_i(1'b0));

  // Random-run drive/observe arrays: index 0 = dut_b, index 1 = dut_c.
  logic          r_v [2];
  logic [PW-1:0] r_p [2];
  logic          r_rdy [2];
  logic          rs_ready [2];
  logic          ro_valid [2];
  logic [PW-1:0] ro_pay [2];
  logic [FWR-1:0] r_fill [2];

  assign b_in.valid = r_v[0];
  assign {b_in.data, b_in.empty, b_in.sop, b_in.eop} = r_p[0];
  assign b_out.ready = r_rdy[0];
  assign c_in.valid = r_v[1];
  assign {c_in.data, c_in.empty, c_in.sop, c_in.eop} = r_p[1];
  assign c_out.ready = r_rdy[1];
  assign rs_ready[0] = b_in.ready;
  assign rs_ready[1] = c_in.ready;
  assign ro_valid[0] = b_out.valid;
  assign ro_valid[1] = c_out.valid;
  assign ro_pay[0] = {b_out.data, b_out.empty, b_out.sop, b_out.eop};
  assign ro_pay[1] = {c_out.data, c_out.empty, c_out.sop, c_out.eop};
  assign r_fill[0] = b_fill;
  assign r_fill[1] = c_fill;

  // Scoreboards
  logic [PW-1:0] a_q[$];
  logic [PW-1:0] qb[$];
  logic [PW-1:0] qc[$];

  // dut_a per-cycle observations
  logic          a_sf, a_of, a_obs_valid;
  logic [PW-1:0] a_obs_pay;
  logic [FWA-1:0] a_obs_fill;
  int            a_cyc_at;
  int            a_fill_m = 0;

  typedef struct {
    logic v;
    logic sop;
    logic eop;
    logic clr;
    logic exp_err;
  } fr_vec_t;
  fr_vec_t fr [20];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  task automatic drive_a(input logic v, input logic [DW-1:0] d, input logic [EW-1:0] e,
                         input logic s, input logic p);
    a_in.valid = v;
    a_in.data  = d;
    a_in.empty = e;
    a_in.sop   = s;
    a_in.eop   = p;
  endtask

  // One clock of dut_a: sample at negedge, check fill model and beats,
  // then return 1 time unit after the next rising edge.
  task automatic a_cycle();
    logic [PW-1:0] e;
    @(negedge clk);
    a_cyc_at    = cyc;
    a_obs_fill  = a_fill;
    a_obs_valid = a_out.valid;
    a_obs_pay   = {a_out.data, a_out.empty, a_out.sop, a_out.eop};
    chk("a_fill_model", a_fill, a_fill_m);
    a_sf = a_in.valid && a_in.ready;
    a_of = a_out.valid && a_out.ready;
    if (a_of) begin
      if (a_q.size() == 0) fail_now("a_unexpected_beat");
      else begin
        e = a_q.pop_front();
        chk("a_beat", a_obs_pay, e);
      end
    end
    if (a_sf) a_q.push_back({a_in.data, a_in.empty, a_in.sop, a_in.eop});
    a_fill_m = a_fill_m + int'(a_sf) - int'(a_of);
    @(posedge clk);
    #1;
  endtask

  task automatic run_random();
    int sent [2];
    int got [2];
    int fm [2];
    logic sf, of;
    logic [PW-1:0] e;
    int t;
    for (int k = 0; k < 2; k++) begin
      sent[k] = 0; got[k] = 0; fm[k] = 0;
    end
    for (t = 0; t < 30000 && (got[0] < 1000 || got[1] < 1000); t++) begin
      for (int k = 0; k < 2; k++) begin
        r_v[k]   = (sent[k] < 1000) && ($urandom_range(0, 1) == 1);
        r_p[k]   = {$urandom(), $urandom(), 3'($urandom_range(0, 7)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))};
        r_rdy[k] = ($urandom_range(0, 1) == 1);
      end
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("rand_fill_%0d", k), r_fill[k], fm[k]);
        sf = r_v[k] && rs_ready[k];
        of = ro_valid[k] && r_rdy[k];
        if (of) begin
          if ((k == 0 ? qb.size() : qc.size()) == 0) fail_now($sformatf("rand_unexpected_%0d", k));
          else begin
            e = (k == 0) ? qb.pop_front() : qc.pop_front();
            chk($sformatf("rand_beat_%0d", k), ro_pay[k], e);
          end
        end
        if (sf) begin
          if (k == 0) qb.push_back(r_p[k]);
          else        qc.push_back(r_p[k]);
        end
        fm[k]   = fm[k] + int'(sf) - int'(of);
        sent[k] = sent[k] + int'(sf);
        got[k]  = got[k] + int'(of);
      end
      @(posedge clk);
      #1;
    end
    chk("rand_done_skid", got[0], 1000);
    chk("rand_done_fwd", got[1], 1000);
    for (int k = 0; k < 2; k++) begin
      r_v[k] = 1'b0;
      r_rdy[k] = 1'b0;
    end
  endtask

  initial begin
    int sent, got, first_sink, first_src, prev_src, bubbles;
    logic [EW-1:0] last_empty;

    for (int k = 0; k < 2; k++) begin
      r_v[k] = 1'b0; r_p[k] = '0; r_rdy[k] = 1'b0;
    end
    a_clr = 1'b0;
    a_out.ready = 1'b0;
    drive_a(1'b0, '0, '0, 1'b0, 1'b0);

    fr[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    fr[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    fr[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    fr[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    fr[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    fr[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    fr[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    fr[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    fr[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    fr[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    fr[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    fr[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    fr[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    fr[13] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    fr[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    fr[15] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    fr[16] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    fr[17] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    fr[18] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    fr[19] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset and release
    #22;
    chk("rst_sink_ready", a_in.ready, 0);
    chk("rst_src_valid", a_out.valid, 0);
    chk("rst_fill", a_fill, 0);
    chk("rst_err", a_err, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("release_ready_pre_edge", a_in.ready, 0);
    @(posedge clk); #1;
    chk("release_ready", a_in.ready, 1);

    // Streaming 16-beat packet, ready held high
    a_out.ready = 1'b1;
    sent = 0; got = 0; first_sink = -1; first_src = -1; prev_src = -1; bubbles = 0;
    last_empty = '0;
    for (int t = 0; t < 60 && got < 16; t++) begin
      if (sent < 16) drive_a(1'b1, DW'(sent), (sent == 15) ? EW'(3) : EW'(0), sent == 0, sent == 15);
      else           drive_a(1'b0, '0, '0, 1'b0, 1'b0);
      a_cycle();
      if (a_sf) begin
        if (first_sink < 0) first_sink = a_cyc_at;
        sent++;
      end
      if (a_of) begin
        if (first_src < 0) first_src = a_cyc_at;
        else if (a_cyc_at != prev_src + 1) bubbles++;
        prev_src = a_cyc_at;
        chk("stream_data", a_obs_pay[PW-1 -: DW], got);
        if (got < 15) chk("stream_fill", a_obs_fill, 2);
        last_empty = a_obs_pay[EW+1:2];
        got++;
      end
    end
    chk("stream_count", got, 16);
    chk("stream_latency", first_src - first_sink, 2);
    chk("stream_bubbles", bubbles, 0);
    chk("stream_last_empty", last_empty, 3);

    // Backpressure: ready low while offering 10 beats
    a_out.ready = 1'b0;
    sent = 0; got = 0;
    for (int t = 0; t < 12; t++) begin
      drive_a(1'b1, DW'(100 + sent), '0, sent == 0, sent == 9);
      a_cycle();
      if (a_sf) sent++;
    end
    chk("bp_accepted", sent, 4);
    chk("bp_fill", a_fill, 4);
    chk("bp_sink_ready", a_in.ready, 0);
    a_out.ready = 1'b1;
    for (int t = 0; t < 60 && got < 10; t++) begin
      if (sent < 10) drive_a(1'b1, DW'(100 + sent), '0, sent == 0, sent == 9);
      else           drive_a(1'b0, '0, '0, 1'b0, 1'b0);
      a_cycle();
      if (a_sf) sent++;
      if (a_of) begin
        chk("bp_order", a_obs_pay[PW-1 -: DW], 100 + got);
        got++;
      end
    end
    chk("bp_drained", got, 10);

    // Framing monitor table
    chk("frame_start_clean", a_err, 0);
    for (int i = 0; i < 20; i++) begin
      drive_a(fr[i].v, DW'(200 + i), '0, fr[i].sop, fr[i].eop);
      a_clr = fr[i].clr;
      a_cycle();
      chk($sformatf("frame_err_%0d", i), a_err, fr[i].exp_err);
    end
    a_clr = 1'b0;
    drive_a(1'b0, '0, '0, 1'b0, 1'b0);
    for (int t = 0; t < 6; t++) a_cycle();

    // Mid-packet asynchronous reset with 3 beats buffered
    a_out.ready = 1'b0;
    sent = 0;
    for (int t = 0; t < 10 && sent < 3; t++) begin
      drive_a(1'b1, DW'(300 + sent), '0, sent == 0, 1'b0);
      a_cycle();
      if (a_sf) sent++;
    end
    drive_a(1'b0, '0, '0, 1'b0, 1'b0);
    chk("mid_fill_before", a_fill, 3);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    chk("mid_src_valid", a_out.valid, 0);
    chk("mid_sink_ready", a_in.ready, 0);
    chk("mid_fill", a_fill, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    a_q.delete();
    a_fill_m = 0;
    a_out.ready = 1'b1;
    @(posedge clk); #1;
    chk("mid_release_ready", a_in.ready, 1);
    for (int t = 0; t < 4; t++) begin
      a_cycle();
      chk("mid_no_stale", a_obs_valid, 0);
    end
    sent = 0; got = 0;
    for (int t = 0; t < 20 && got < 2; t++) begin
      if (sent < 2) drive_a(1'b1, DW'(400 + sent), '0, sent == 0, sent == 1);
      else          drive_a(1'b0, '0, '0, 1'b0, 1'b0);
      a_cycle();
      if (a_sf) sent++;
      if (a_of) got++;
    end
    chk("mid_post_pkt", got, 2);
    chk("mid_post_err", a_err, 0);

    // Random valid/ready on STAGES=3 skid and forward pipes
    run_random();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
